// File: rtl/cla_accum_pkg.sv
// Shared types and constants for the streaming CLA accumulator.
package cla_accum_pkg;

  localparam int ACC_W = 32;
  localparam logic [ACC_W-1:0] ACC_MAX = 32'hFFFFFFFF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/CLA32Bit.sv
// 32-bit carry-lookahead adder: eight 4-bit lookahead groups whose group
// carries chain from one group to the next.
module CLA32Bit (
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        Cin,
  output logic [31:0] S,
  output logic        Cout
);

  logic [31:0] g;
  logic [31:0] p;
  logic [32:0] c;

  genvar gi;
  generate
    for (gi = 0; gi < 32; gi++) begin : gen_gp
      assign g[gi] = A[gi] & B[gi];
      assign p[gi] = A[gi] ^ B[gi];
    end
  endgenerate

  // Within each group every carry is expanded from the group carry-in only.
  always_comb begin
    c    = '0;
    c[0] = Cin;
    for (int k = 0; k < 8; k++) begin
      c[4*k+1] = g[4*k] | (p[4*k] & c[4*k]);
      c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k])
               | (p[4*k+1] & p[4*k] & c[4*k]);
      c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1])
               | (p[4*k+2] & p[4*k+1] & g[4*k])
               | (p[4*k+2] & p[4*k+1] & p[4*k] & c[4*k]);
      c[4*k+4] = g[4*k+3] | (p[4*k+3] & g[4*k+2])
               | (p[4*k+3] & p[4*k+2] & g[4*k+1])
               | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k])
               | (p[4*k+3] & p[4*k+2] & p[4*k+1] & p[4*k] & c[4*k]);
    end
  end

  assign S    = p ^ c[31:0];
  assign Cout = c[32];

endmodule

// File: rtl/cla_stream_accum.sv
// Streaming accumulator around CLA32Bit: loads an initial value, adds a burst
// of input words, counts carry-outs and offers the total on a valid/ready port.
// Optional build macro CLA_ACCUM_SAT_EN clamps the total at all-ones on carry.
module cla_stream_accum
  import cla_accum_pkg::*;
#(
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic [ACC_W-1:0] init,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [ACC_W-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] sum,
  output logic [LEN_W-1:0] carry_cnt,
  output logic             busy
);

  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);
  localparam logic [LEN_W-1:0] CNT_MAX = '1;

  state_e           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [LEN_W-1:0] remaining_q, remaining_d;
  logic [LEN_W-1:0] carry_cnt_q, carry_cnt_d;
  logic [ACC_W-1:0] add_s;
  logic             add_cout;

  CLA32Bit u_cla (
    .A    (acc_q),
    .B    (in_data),
    .Cin  (1'b0),
    .S    (add_s),
    .Cout (add_cout)
  );

  // Handshake outputs come from the state register only.
  assign in_ready  = (state_q == ACCUM);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign sum       = acc_q;
  assign carry_cnt = carry_cnt_q;

  // Next-state and datapath update for the burst sequencer.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    remaining_d = remaining_q;
    carry_cnt_d = carry_cnt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          acc_d       = init;
          remaining_d = len;
          carry_cnt_d = '0;
          state_d     = (len == '0) ? DONE : ACCUM;
        end
      end
      ACCUM: begin
        if (in_valid) begin
`ifdef CLA_ACCUM_SAT_EN
          acc_d = add_cout ? ACC_MAX : add_s;
`else
          acc_d = add_s;
`endif
          if (add_cout && (carry_cnt_q != CNT_MAX)) begin
            carry_cnt_d = carry_cnt_q + LEN_ONE;
          end
          remaining_d = remaining_q - LEN_ONE;
          if (remaining_q == LEN_ONE) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      remaining_q <= '0;
      carry_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      remaining_q <= remaining_d;
      carry_cnt_q <= carry_cnt_d;
    end
  end

endmodule
